// File: rtl/alu_pkg.sv
// Shared opcode and shifter-mode definitions for the ALU and the decoder
// that drives it.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SHL   = 4'b0101,
    ALU_SHR   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_ROTR  = 4'b1000,
    ALU_ROTL  = 4'b1001,
    ALU_NOTA  = 4'b1010,
    ALU_PASSB = 4'b1011
  } alu_op_e;

  typedef enum logic [2:0] {
    SH_SHL  = 3'd0,
    SH_SHR  = 3'd1,
    SH_SRA  = 3'd2,
    SH_ROTR = 3'd3,
    SH_ROTL = 3'd4
  } shift_mode_e;

  // Non-shift opcodes map to SH_SHL; their shifter output is simply unused.
  function automatic shift_mode_e shift_mode_of(input alu_op_e op);
    case (op)
      ALU_SHR:  return SH_SHR;
      ALU_SRA:  return SH_SRA;
      ALU_ROTR: return SH_ROTR;
      ALU_ROTL: return SH_ROTL;
      default:  return SH_SHL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit. Shifts saturate for amounts >= N;
// rotates use the amount modulo N.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] amount,
  input  shift_mode_e  mode,
  output logic [N-1:0] result
);

  localparam logic [N-1:0] WIDTH = N'(N);

  logic           big;
  logic [N-1:0]   rot;
  logic [2*N-1:0] dbl_r;
  logic [2*N-1:0] dbl_l;

  // Rotating the doubled word lets one barrel shift cover both directions.
  always_comb begin
    big   = (amount >= WIDTH);
    rot   = amount % WIDTH;
    dbl_r = {a, a} >> rot;
    dbl_l = {a, a} << rot;
    case (mode)
      SH_SHL:  result = big ? '0 : (a << amount);
      SH_SHR:  result = big ? '0 : (a >> amount);
      SH_SRA:  result = big ? {N{a[N-1]}} : $unsigned($signed(a) >>> amount);
      SH_ROTR: result = dbl_r[N-1:0];
      SH_ROTL: result = dbl_l[2*N-1:N];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Single-cycle-latency ALU: combinational datapath and flags, then one
// register stage holding AluResult, z and n.
module alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N:0]   AluControl,
  output logic [N-1:0] AluResult,
  output logic         z,
  output logic         n
);

  alu_op_e     op;
  shift_mode_e mode;
  logic [N-1:0] shift_res;
  logic [N-1:0] next_res;

  assign op   = alu_op_e'(AluControl[3:0]);
  assign mode = shift_mode_of(op);

  // Control bits above [3:0] carry no meaning for this block.
  if (N > 3) begin : g_unused_ctrl
    logic unused_ctrl;
    assign unused_ctrl = ^AluControl[N:4];
  end

  alu_shifter #(.N(N)) u_shifter (
    .a      (a),
    .amount (b),
    .mode   (mode),
    .result (shift_res)
  );

  always_comb begin
    case (op)
      ALU_ADD:   next_res = a + b;
      ALU_SUB:   next_res = a - b;
      ALU_AND:   next_res = a & b;
      ALU_OR:    next_res = a | b;
      ALU_XOR:   next_res = a ^ b;
      ALU_SHL,
      ALU_SHR,
      ALU_SRA,
      ALU_ROTR,
      ALU_ROTL:  next_res = shift_res;
      ALU_NOTA:  next_res = ~a;
      ALU_PASSB: next_res = b;
      default:   next_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AluResult <= '0;
      z         <= 1'b1;
      n         <= 1'b0;
    end else begin
      AluResult <= next_res;
      z         <= (next_res == '0);
      n         <= next_res[N-1];
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu at N=3: an arithmetic reference model checked
// every cycle, plus hand-computed directed vectors.
module tb_alu;
  import alu_pkg::*;

  localparam int N    = 3;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N:0]   ctrl;
  logic [N-1:0] res;
  logic         z;
  logic         n;

  int checks_total  = 0;
  int checks_passed = 0;
  bit cmp_en = 1'b0;

  int exp_res;
  int exp_z;
  int exp_n;

  alu #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .AluControl (ctrl),
    .AluResult  (res),
    .z          (z),
    .n          (n)
  );

  always #5 clk = ~clk;

  // Reference behaviour from plain integer arithmetic on the operation rules.
  function automatic int model_result(input int av, input int bv, input int code);
    int r;
    int k;
    int sign;
    sign = (av >> (N - 1)) & 1;
    k    = bv % N;
    case (code & 15)
      0:  r = av + bv;
      1:  r = av - bv;
      2:  r = av & bv;
      3:  r = av | bv;
      4:  r = av ^ bv;
      5:  r = (bv >= N) ? 0 : (av << bv);
      6:  r = (bv >= N) ? 0 : (av >> bv);
      7:  begin
        if (bv >= N) r = sign ? MASK : 0;
        else         r = (av >> bv) | (sign ? (MASK << (N - bv)) : 0);
      end
      8:  r = (av >> k) | (av << (N - k));
      9:  r = (av << k) | (av >> (N - k));
      10: r = ~av;
      11: r = bv;
      default: r = 0;
    endcase
    return r & MASK;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_res = 0;
      exp_z   = 1;
      exp_n   = 0;
    end else begin
      exp_res = model_result(int'(a), int'(b), int'(ctrl));
      exp_z   = (exp_res == 0) ? 1 : 0;
      exp_n   = (exp_res >> (N - 1)) & 1;
    end
  end

  task automatic checkEq(input string name, input int actual, input int required);
    checks_total++;
    if (actual == required) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkEq("model_res", int'(res), exp_res);
      checkEq("model_z", int'(z), exp_z);
      checkEq("model_n", int'(n), exp_n);
    end
  end

  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic [3:0] code);
    @(negedge clk);
    a    = av;
    b    = bv;
    ctrl = code;
  endtask

  task automatic checkOutput(input string name, input int er, input int ez, input int en);
    @(posedge clk);
    #1;
    checkEq({name, "_res"}, int'(res), er);
    checkEq({name, "_z"}, int'(z), ez);
    checkEq({name, "_n"}, int'(n), en);
    checkEq({name, "_model"}, exp_res, er);
  endtask

  initial begin
    rst  = 1'b1;
    a    = '0;
    b    = '0;
    ctrl = '0;
    #1;
    checkEq("rst_res", int'(res), 0);
    checkEq("rst_z", int'(z), 1);
    checkEq("rst_n", int'(n), 0);
    repeat (2) @(posedge clk);
    #1;
    checkEq("rst_hold_res", int'(res), 0);
    checkEq("rst_hold_z", int'(z), 1);
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;

    applyStimulus(3'b001, 3'b001, ALU_ADD);   checkOutput("add", 2, 0, 0);
    applyStimulus(3'b111, 3'b100, ALU_AND);   checkOutput("and", 4, 0, 1);
    applyStimulus(3'b010, 3'b110, ALU_OR);    checkOutput("or", 6, 0, 1);
    applyStimulus(3'b111, 3'b101, ALU_XOR);   checkOutput("xor", 2, 0, 0);
    applyStimulus(3'b101, 3'b101, ALU_SUB);   checkOutput("sub_zero", 0, 1, 0);
    applyStimulus(3'b110, 3'b001, ALU_SRA);   checkOutput("sra", 7, 0, 1);
    applyStimulus(3'b110, 3'b001, ALU_SHR);   checkOutput("shr", 3, 0, 0);
    applyStimulus(3'b110, 3'b011, ALU_SHL);   checkOutput("shl_big", 0, 1, 0);
    applyStimulus(3'b001, 3'b100, ALU_ROTR);  checkOutput("rotr_mod", 4, 0, 1);
    applyStimulus(3'b111, 3'b111, 4'b1111);   checkOutput("undef", 0, 1, 0);
    applyStimulus(3'b111, 3'b001, ALU_ADD);   checkOutput("add_wrap", 0, 1, 0);
    applyStimulus(3'b000, 3'b001, ALU_SUB);   checkOutput("sub_wrap", 7, 0, 1);
    applyStimulus(3'b011, 3'b001, ALU_ROTL);  checkOutput("rotl", 6, 0, 1);
    applyStimulus(3'b101, 3'b011, ALU_ROTR);  checkOutput("rotr_zero", 5, 0, 1);
    applyStimulus(3'b100, 3'b101, ALU_SRA);   checkOutput("sra_big", 7, 0, 1);
    applyStimulus(3'b100, 3'b101, ALU_SHR);   checkOutput("shr_big", 0, 1, 0);
    applyStimulus(3'b010, 3'b000, ALU_NOTA);  checkOutput("nota", 5, 0, 1);
    applyStimulus(3'b000, 3'b110, ALU_PASSB); checkOutput("passb", 6, 0, 1);
    applyStimulus(3'b001, 3'b010, ALU_SHL);   checkOutput("shl", 4, 0, 1);

    for (int code = 0; code < 16; code++) begin
      for (int av = 0; av <= MASK; av++) begin
        for (int bv = 0; bv <= MASK; bv++) begin
          applyStimulus(N'(av), N'(bv), 4'(code));
        end
      end
    end

    applyStimulus(3'b011, 3'b010, ALU_ADD);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkEq("async_rst_res", int'(res), 0);
    checkEq("async_rst_z", int'(z), 1);
    checkEq("async_rst_n", int'(n), 0);
    applyStimulus(3'b011, 3'b001, ALU_ADD);
    @(posedge clk);
    #1;
    checkEq("rst_held_res", int'(res), 0);
    checkEq("rst_held_z", int'(z), 1);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("post_rst", 4, 0, 1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand/result width in bits (legal N >= 2).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have port a  input  N  operand A.
REQ-005 The block SHALL have port b  input  N  operand B; also the shift/rotate amount.
REQ-006 The block SHALL have port AluControl  input  N+1  operation select; only bits [3:0] decoded, higher bits ignored.
REQ-007 The block SHALL have port AluResult  output  N  registered result.
REQ-008 The block SHALL have port z  output  1  registered zero flag.
REQ-009 The block SHALL have port n  output  1  registered negative flag.

Function
REQ-010 The block SHALL sample a, b and AluControl on each rising clk edge and present AluResult, z and n from that sample, with one-cycle latency, no handshake and a new operation every cycle.
REQ-011 The block SHALL decode AluControl[3:0] as: 0000 ADD a+b; 0001 SUB a-b; 0010 AND; 0011 OR; 0100 XOR; 0101 SHL a<<b; 0110 SHR logical a>>b; 0111 SRA arithmetic a>>>b; 1000 ROTR a by b; 1001 ROTL a by b; 1010 NOT a; 1011 PASS b.
REQ-012 The block SHALL output all zeros for codes 1100-1111.
REQ-013 The block SHALL wrap ADD/SUB modulo 2^N, discard carry-out and report no overflow.
REQ-014 The block SHALL treat shift amounts as unsigned b: for b >= N, SHL/SHR give 0 and SRA gives N copies of a[N-1].
REQ-015 The block SHALL rotate by (b mod N); rotation by 0 returns a unchanged.
REQ-016 The block SHALL set z = 1 iff the registered AluResult equals 0 on every code, including undefined codes.
REQ-017 The block SHALL set n = AluResult[N-1] on every code.
REQ-018 The block SHALL update the flags in the same cycle as AluResult, with no separate flag-enable.

Reset
REQ-019 The block SHALL force AluResult = 0, z = 1 and n = 0 immediately on rst assertion, independent of clk.
REQ-020 The block SHALL hold those reset values while rst is high, discarding any in-flight operation.
REQ-021 The block SHALL resume with the first rising clk edge after rst deasserts, registering the inputs present at that edge.

Structure
REQ-022 The block SHALL place the 4-bit opcode enum (ALU_ADD ... ALU_PASSB) in a shared package alu_pkg for use by the decoder/control unit.
REQ-023 The block SHALL implement shifts and rotates in one combinational sub-module alu_shifter (inputs a, amount, mode; output N-bit result), instantiated once.
REQ-024 The block SHALL implement the arithmetic, logic and flag path in a combinational section, followed by one register stage holding AluResult, z and n.

Verification (N=3; check one cycle after the applying edge)
REQ-025 The bench SHALL check: a=001, b=001, ADD -> AluResult=010, z=0, n=0.
REQ-026 The bench SHALL check: a=111, b=100, AND -> 100, z=0, n=1; then a=010, b=110, OR -> 110, n=1.
REQ-027 The bench SHALL check: a=111, b=101, XOR -> 010, z=0, n=0; then a=101, b=101, SUB -> 000, z=1, n=0.
REQ-028 The bench SHALL check: a=110, b=001, SRA -> 111, n=1; SHR -> 011; SHL with b=011 -> 000, z=1; ROTR a=001, b=100 -> 100.
REQ-029 The bench SHALL check: code 1111 with a=111, b=111 -> 000, z=1.
REQ-030 The bench SHALL check: rst asserted mid-stream between clk edges -> outputs go to 0/1/0 immediately; after release, the next edge yields the correct result.
